// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the two-port ROM read arbiter.
package rom_arb_pkg;

    // Default geometry of the shared ROM.
    localparam int unsigned ROM_ADDR_W = 13;
    localparam int unsigned ROM_DATA_W = 16;
    localparam int unsigned ROM_DEPTH  = 8100;

    // Priority policy names accepted by the PRIO parameter.
    localparam string PRIO_RR   = "RR";
    localparam string PRIO_FIX0 = "FIX0";

    // Index of the requester that won most recently.
    typedef enum logic {
        L0 = 1'b0,
        L1 = 1'b1
    } last_e;

    // Decoded priority policy.
    typedef enum logic {
        PrioRr   = 1'b0,
        PrioFix0 = 1'b1
    } prio_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner selection: round-robin on LAST or fixed priority to requester 0.
module rr_pick2
    import rom_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  last_e      last,
    input  prio_e      prio,
    output logic [1:0] gnt
);

    // One-hot pick; a tie goes to the requester that did not win last time.
    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            if (prio == PrioFix0 || last == L1) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/rom_share_arb.sv
// Shares one synchronous-read ROM between two requesters, one read per cycle.
module rom_share_arb
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = ROM_DATA_W,
    parameter int unsigned DEPTH  = ROM_DEPTH,
    parameter string       PRIO   = PRIO_RR
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              rerr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_do,
    output logic              rom_rst
);

    localparam prio_e PrioSel = (PRIO == PRIO_FIX0) ? PrioFix0 : PrioRr;

    // One extra bit so a DEPTH of exactly 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        pick_gnt;
    logic [1:0]        gnt_vec;
    logic              oor_now;

    last_e             last_q, last_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              oor_q, oor_d;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .prio (PrioSel),
        .gnt  (pick_gnt)
    );

    // Grant gating, ROM address steering and next-state for the read pipeline.
    always_comb begin
        gnt_vec = rsta ? 2'b00 : pick_gnt;

        if (gnt_vec[0]) begin
            rom_addr = addr0;
        end else if (gnt_vec[1]) begin
            rom_addr = addr1;
        end else begin
            rom_addr = addr_hold_q;
        end

        oor_now = (gnt_vec != 2'b00) && ({1'b0, rom_addr} >= DepthLim);

        last_d = last_q;
        if (gnt_vec[0]) begin
            last_d = L0;
        end else if (gnt_vec[1]) begin
            last_d = L1;
        end

        addr_hold_d = rom_addr;
        rvalid0_d   = gnt_vec[0];
        rvalid1_d   = gnt_vec[1];
        oor_d       = oor_now;
    end

    // Pipeline state; reset drops any read in flight and biases the first tie to requester 0.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            last_q      <= L1;
            addr_hold_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            last_q      <= last_d;
            addr_hold_q <= addr_hold_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            oor_q       <= oor_d;
        end
    end

    // Output drive; data is zeroed unless an in-range read is landing this cycle.
    always_comb begin
        gnt0    = gnt_vec[0];
        gnt1    = gnt_vec[1];
        rvalid0 = rvalid0_q;
        rvalid1 = rvalid1_q;
        rerr    = oor_q;
        rom_rst = rsta;
        rdata   = ((rvalid0_q || rvalid1_q) && !oor_q) ? rom_do : '0;
    end

endmodule
